// File: rtl/render_box.sv
// Rectangle rasteriser: walks a latched rectangle in raster order, classifies
// border/interior, clips to the screen and streams pixels over valid/ready.
module render_box #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = 3,
    parameter int BT_W     = 4,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     origin_x,
    input  logic [Y_W-1:0]     origin_y,
    input  logic [X_W-1:0]     width,
    input  logic [Y_W-1:0]     height,
    input  logic [COLOR_W-1:0] back_color,
    input  logic [COLOR_W-1:0] border_color,
    input  logic [BT_W-1:0]    border_thickness,
    input  logic               fill,
    output logic               busy,
    output logic               done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W-1:0]     x_stream,
    output logic [Y_W-1:0]     y_stream,
    output logic [COLOR_W-1:0] color_stream
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [X_W:0] SCREEN_X = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCREEN_Y = (Y_W+1)'(SCREEN_H);

    state_t state_reg, state_next;

    logic [X_W-1:0]     ox_reg, w_reg, cx_reg, cx_next;
    logic [Y_W-1:0]     oy_reg, h_reg, cy_reg, cy_next;
    logic [COLOR_W-1:0] bc_reg, brc_reg;
    logic [BT_W-1:0]    bt_reg;
    logic               fill_reg;
    logic               done_next;

    logic               out_free;
    logic [X_W:0]       x_sum, cx_ext, w_ext, bt_x;
    logic [Y_W:0]       y_sum, cy_ext, h_ext, bt_y;
    logic               border_x, border_y, border, emit;
    logic               last_x, last_y;

    assign out_free = !pix_valid || pix_ready;
    assign busy     = (state_reg != IDLE);

    // Wide comparisons so origin+offset never wraps back on-screen.
    assign cx_ext = {1'b0, cx_reg};
    assign cy_ext = {1'b0, cy_reg};
    assign w_ext  = {1'b0, w_reg};
    assign h_ext  = {1'b0, h_reg};
    assign bt_x   = (X_W+1)'(bt_reg);
    assign bt_y   = (Y_W+1)'(bt_reg);
    assign x_sum  = {1'b0, ox_reg} + cx_ext;
    assign y_sum  = {1'b0, oy_reg} + cy_ext;

    // bt >= extent makes w-bt meaningless, so it forces border explicitly.
    assign border_x = (cx_ext < bt_x) || (bt_x >= w_ext) || (cx_ext >= w_ext - bt_x);
    assign border_y = (cy_ext < bt_y) || (bt_y >= h_ext) || (cy_ext >= h_ext - bt_y);
    assign border   = border_x || border_y;
    assign emit     = (x_sum < SCREEN_X) && (y_sum < SCREEN_Y) && (fill_reg || border);

    assign last_x = (cx_reg == w_reg - X_W'(1));
    assign last_y = (cy_reg == h_reg - Y_W'(1));

    always_comb begin
        state_next = state_reg;
        cx_next    = cx_reg;
        cy_next    = cy_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cx_next    = '0;
                    cy_next    = '0;
                    state_next = (width == '0 || height == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (out_free) begin
                    if (last_x) begin
                        cx_next = '0;
                        if (last_y) begin
                            state_next = DRAIN;
                        end else begin
                            cy_next = cy_reg + Y_W'(1);
                        end
                    end else begin
                        cx_next = cx_reg + X_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_free) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cx_reg       <= '0;
            cy_reg       <= '0;
            ox_reg       <= '0;
            oy_reg       <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            bc_reg       <= '0;
            brc_reg      <= '0;
            bt_reg       <= '0;
            fill_reg     <= 1'b0;
            done         <= 1'b0;
            pix_valid    <= 1'b0;
            x_stream     <= '0;
            y_stream     <= '0;
            color_stream <= '0;
        end else begin
            state_reg <= state_next;
            cx_reg    <= cx_next;
            cy_reg    <= cy_next;
            done      <= done_next;
            if (state_reg == IDLE && start) begin
                ox_reg   <= origin_x;
                oy_reg   <= origin_y;
                w_reg    <= width;
                h_reg    <= height;
                bc_reg   <= back_color;
                brc_reg  <= border_color;
                bt_reg   <= border_thickness;
                fill_reg <= fill;
            end
            // Output register only moves when the sink has taken (or never had) a pixel.
            if (out_free) begin
                pix_valid <= (state_reg == RUN) && emit;
                if (state_reg == RUN && emit) begin
                    x_stream     <= x_sum[X_W-1:0];
                    y_stream     <= y_sum[Y_W-1:0];
                    color_stream <= border ? brc_reg : bc_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_render_box.sv
// Scoreboard bench for render_box: a raster-loop reference model fills an
// expected-pixel queue, a negedge monitor pops and compares accepted pixels.
module tb_render_box;

    logic       clk = 0;
    logic       reset;
    logic       start;
    logic [8:0] origin_x, width;
    logic [7:0] origin_y, height;
    logic [2:0] back_color, border_color;
    logic [3:0] border_thickness;
    logic       fill;
    logic       busy, done, pix_valid, pix_ready;
    logic [8:0] x_stream;
    logic [7:0] y_stream;
    logic [2:0] color_stream;

    render_box dut (
        .clk(clk), .reset(reset), .start(start),
        .origin_x(origin_x), .origin_y(origin_y), .width(width), .height(height),
        .back_color(back_color), .border_color(border_color),
        .border_thickness(border_thickness), .fill(fill),
        .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .x_stream(x_stream), .y_stream(y_stream), .color_stream(color_stream)
    );

    always #10 clk = ~clk;

    typedef struct {int x; int y; int c;} pix_t;
    pix_t q[$];

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int ready_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ready: 0 = always, 1 = alternating, 2 = random
    initial begin
        pix_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: pix_ready = 1;
                1: pix_ready = !pix_ready;
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        bit   prev_stall = 0;
        int   px = 0, py = 0, pc = 0;
        pix_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!pix_valid || x_stream != px || y_stream != py || color_stream != pc) begin
                        errors++;
                        $display("FAIL hold: got v=%0d (%0d,%0d,c%0d) expected v=1 (%0d,%0d,c%0d)",
                                 pix_valid, x_stream, y_stream, color_stream, px, py, pc);
                    end
                end
                if (pix_valid && pix_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL pixel: got unexpected (%0d,%0d,c%0d) expected none",
                                 x_stream, y_stream, color_stream);
                    end else begin
                        e = q.pop_front();
                        if (x_stream != e.x || y_stream != e.y || color_stream != e.c) begin
                            errors++;
                            $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                                     x_stream, y_stream, color_stream, e.x, e.y, e.c);
                        end
                    end
                end
                if (pix_valid && !pix_ready) stall_cnt++;
                prev_stall = pix_valid && !pix_ready;
                px = x_stream;
                py = y_stream;
                pc = color_stream;
            end
        end
    end

    // Reference: plain nested loops over the rectangle.
    task automatic model(input int ox, input int oy, input int w, input int h,
                         input int bc, input int brc, input int bt, input bit f);
        pix_t p;
        bit   b;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                b = (bt > 0) && (x < bt || x >= w - bt || y < bt || y >= h - bt);
                if (ox + x < 320 && oy + y < 240 && (f || b)) begin
                    p.x = ox + x;
                    p.y = oy + y;
                    p.c = b ? brc : bc;
                    q.push_back(p);
                end
            end
        end
    endtask

    // Called between clock edges; returns at the negedge of the done cycle.
    task automatic run_rect(input string tag, input int ox, input int oy, input int w, input int h,
                            input int bc, input int brc, input int bt, input bit f,
                            input int mode, input bit inject, input int exp_pix);
        int  cyc, budget;
        bit  got;
        ready_mode = mode;
        model(ox, oy, w, h, bc, brc, bt, f);
        if (exp_pix >= 0) chk({tag, "_npix"}, q.size(), exp_pix);
        stall_cnt = 0;
        origin_x = 9'(ox); origin_y = 8'(oy); width = 9'(w); height = 8'(h);
        back_color = 3'(bc); border_color = 3'(brc); border_thickness = 4'(bt); fill = f;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        cyc = 1;
        got = 0;
        budget = w * h * 4 + 50;
        while (!got && cyc < budget) begin
            @(negedge clk);
            if (cyc == 1) chk({tag, "_busy_c1"}, busy, 1);
            if (inject && cyc == 3) begin
                start = 1; origin_x = 0; origin_y = 0; width = 2; height = 2; fill = 1;
            end
            if (inject && cyc == 4) start = 0;
            if (done) got = 1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_done_cycle"}, cyc, w * h + 2 + stall_cnt);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_left_in_queue"}, q.size(), 0);
        q.delete();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1; start = 0; fill = 0;
        origin_x = 0; origin_y = 0; width = 0; height = 0;
        back_color = 0; border_color = 0; border_thickness = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_x", x_stream, 0);

        run_rect("fill",     10, 20, 4, 3, 2, 5, 1, 1, 0, 0, 12);
        run_rect("outline",  10, 20, 4, 3, 2, 5, 1, 0, 0, 0, 10);
        run_rect("clip",    318, 238, 4, 4, 6, 1, 0, 1, 0, 0, 4);
        run_rect("bp",       50, 60, 2, 2, 3, 4, 0, 1, 1, 0, 4);
        run_rect("w0",       5, 5, 0, 3, 1, 2, 1, 1, 0, 0, 0);
        run_rect("h0",       5, 5, 3, 0, 1, 2, 1, 1, 0, 0, 0);
        run_rect("bt2",      7, 8, 3, 3, 1, 6, 2, 1, 0, 0, 9);
        run_rect("bigbt",    0, 0, 5, 4, 1, 7, 15, 0, 2, 0, 20);
        run_rect("inject",  100, 100, 5, 4, 2, 3, 1, 1, 2, 1, 20);

        for (int i = 0; i < 25; i++) begin
            int ox, oy;
            ox = ($urandom_range(0, 1) == 1) ? $urandom_range(305, 330) : $urandom_range(0, 300);
            oy = ($urandom_range(0, 1) == 1) ? $urandom_range(228, 250) : $urandom_range(0, 220);
            run_rect("rand", ox, oy, $urandom_range(0, 12), $urandom_range(0, 12),
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5),
                     1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, -1);
        end

        // Reset in cycle 5 of a 10x10 draw.
        ready_mode = 0;
        @(posedge clk);
        #1;
        model(0, 0, 10, 10, 1, 2, 1, 1);
        origin_x = 0; origin_y = 0; width = 10; height = 10;
        back_color = 1; border_color = 2; border_thickness = 1; fill = 1;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (4) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        q.delete();
        @(negedge clk);
        chk("rst_mid_x", x_stream, 0);
        chk("rst_mid_color", color_stream, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_mid_valid", pix_valid, 0);
            chk("rst_mid_busy", busy, 0);
            chk("rst_mid_done", done, 0);
        end

        run_rect("after_rst", 20, 30, 3, 2, 4, 5, 1, 0, 0, 0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
